// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its sequencer: opcode encodings,
// PSR flag positions and sequencer state encoding.
package alu_pkg;

   typedef logic [3:0] opcode_t;

   localparam opcode_t ADD = 4'b0000;
   localparam opcode_t SUB = 4'b0001;
   localparam opcode_t OR  = 4'b0010;
   localparam opcode_t AND = 4'b0011;
   localparam opcode_t NOR = 4'b0100;
   localparam opcode_t SLT = 4'b0101;
   localparam opcode_t LDI = 4'b1000;

   localparam int PSR_Z = 0;
   localparam int PSR_N = 1;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] EXEC = 2'b01;
   localparam logic [1:0] RESP = 2'b10;

   // True for opcodes that are executed by the ALU itself.
   function automatic logic is_alu_op(input opcode_t opcode);
      logic r;
      case (opcode)
         ADD, SUB, OR, AND, NOR, SLT: r = 1'b1;
         default:                     r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU sequencer.
// slave is the sequencer's view; master is the host/ALU side.
interface alu_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 3
);

   logic             CMD_VALID;
   logic             CMD_READY;
   logic [3:0]       CMD_OPCODE;
   logic [AW-1:0]    CMD_RD;
   logic [AW-1:0]    CMD_RS1;
   logic [AW-1:0]    CMD_RS2;
   logic [WIDTH-1:0] CMD_IMM;

   logic [WIDTH-1:0] ALU_OP1;
   logic [WIDTH-1:0] ALU_OP2;
   logic [3:0]       ALU_OPCODE;
   logic [WIDTH-1:0] ALU_RES;
   logic [1:0]       ALU_PSR;

   logic             RSP_VALID;
   logic             RSP_READY;
   logic [WIDTH-1:0] RSP_DATA;
   logic [1:0]       RSP_PSR;
   logic             RSP_ERR;

   modport slave (
      input  CMD_VALID, CMD_OPCODE, CMD_RD, CMD_RS1, CMD_RS2, CMD_IMM,
      output CMD_READY,
      output ALU_OP1, ALU_OP2, ALU_OPCODE,
      input  ALU_RES, ALU_PSR,
      output RSP_VALID, RSP_DATA, RSP_PSR, RSP_ERR,
      input  RSP_READY
   );

   modport master (
      output CMD_VALID, CMD_OPCODE, CMD_RD, CMD_RS1, CMD_RS2, CMD_IMM,
      input  CMD_READY,
      input  ALU_OP1, ALU_OP2, ALU_OPCODE,
      output ALU_RES, ALU_PSR,
      input  RSP_VALID, RSP_DATA, RSP_PSR, RSP_ERR,
      output RSP_READY
   );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU driven by the sequencer; flags report the result
// as zero (PSR_Z) and negative (PSR_N).
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [3:0]       opcode,
   output logic [WIDTH-1:0] res,
   output logic [1:0]       psr
);

   logic slt_s;

   assign slt_s = ($signed(op1) < $signed(op2)) ? 1'b1 : 1'b0;

   // Operation select; unknown opcodes produce zero.
   always_comb begin
      res = {WIDTH{1'b0}};
      case (opcode)
         ADD:     res = op1 + op2;
         SUB:     res = op1 - op2;
         OR:      res = op1 | op2;
         AND:     res = op1 & op2;
         NOR:     res = ~(op1 | op2);
         SLT:     res = {{(WIDTH-1){1'b0}}, slt_s};
         default: res = {WIDTH{1'b0}};
      endcase
   end

   // Result flags.
   always_comb begin
      psr        = 2'b00;
      psr[PSR_Z] = (res == {WIDTH{1'b0}}) ? 1'b1 : 1'b0;
      psr[PSR_N] = res[WIDTH-1];
   end

endmodule

// File: rtl/alu_regfile.sv
// REGS x WIDTH register file: two combinational read ports, one synchronous
// write port, synchronous reset of every entry to zero.
module alu_regfile #(
   parameter int WIDTH = 32,
   parameter int REGS  = 8,
   parameter int AW    = $clog2(REGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    rd_addr_a,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data
);

   logic [WIDTH-1:0] mem_q [REGS];
   logic [WIDTH-1:0] mem_d [REGS];

   assign rd_data_a = mem_q[rd_addr_a];
   assign rd_data_b = mem_q[rd_addr_b];

   // Next-state of the storage array: a single-entry write when enabled.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[wr_addr] = wr_data;
      end else begin
         mem_d[wr_addr] = mem_q[wr_addr];
      end
   end

   // Storage flops with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REGS; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Single-command-in-flight controller: reads operands from the register file,
// drives the ALU, writes the result back and returns it on the response channel.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int REGS  = 8
) (
   input  logic            CLK,
   input  logic            RST,
   alu_sequencer_if.slave  bus
);

   localparam int AW = $clog2(REGS);

   logic [1:0]       state_q,      state_d;
   logic [3:0]       op_q,         op_d;
   logic [AW-1:0]    rd_q,         rd_d;
   logic [WIDTH-1:0] imm_q,        imm_d;
   logic [WIDTH-1:0] alu_op1_q,    alu_op1_d;
   logic [WIDTH-1:0] alu_op2_q,    alu_op2_d;
   logic [3:0]       alu_opcode_q, alu_opcode_d;
   logic [WIDTH-1:0] rsp_data_q,   rsp_data_d;
   logic [1:0]       rsp_psr_q,    rsp_psr_d;
   logic             rsp_err_q,    rsp_err_d;
   logic             rsp_valid_q,  rsp_valid_d;
   logic             cmd_ready_q,  cmd_ready_d;

   logic [WIDTH-1:0] rs1_data_s;
   logic [WIDTH-1:0] rs2_data_s;
   logic             we_s;
   logic [WIDTH-1:0] wr_data_s;
   logic [1:0]       ldi_psr_s;

   alu_regfile #(
      .WIDTH (WIDTH),
      .REGS  (REGS),
      .AW    (AW)
   ) u_regfile (
      .clk       (CLK),
      .rst       (RST),
      .rd_addr_a (bus.CMD_RS1),
      .rd_addr_b (bus.CMD_RS2),
      .rd_data_a (rs1_data_s),
      .rd_data_b (rs2_data_s),
      .we        (we_s),
      .wr_addr   (rd_q),
      .wr_data   (wr_data_s)
   );

   // Flags for LDI are derived here since the ALU is bypassed.
   always_comb begin
      ldi_psr_s        = 2'b00;
      ldi_psr_s[PSR_Z] = (imm_q == {WIDTH{1'b0}}) ? 1'b1 : 1'b0;
      ldi_psr_s[PSR_N] = imm_q[WIDTH-1];
   end

   // Sequencer FSM and datapath next-state.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      rd_d         = rd_q;
      imm_d        = imm_q;
      alu_op1_d    = alu_op1_q;
      alu_op2_d    = alu_op2_q;
      alu_opcode_d = alu_opcode_q;
      rsp_data_d   = rsp_data_q;
      rsp_psr_d    = rsp_psr_q;
      rsp_err_d    = rsp_err_q;
      we_s         = 1'b0;
      wr_data_s    = {WIDTH{1'b0}};
      case (state_q)
         IDLE: begin
            if (bus.CMD_VALID) begin
               op_d  = bus.CMD_OPCODE;
               rd_d  = bus.CMD_RD;
               imm_d = bus.CMD_IMM;
               // ALU inputs only move for ALU ops; LDI/illegal leave them as they were.
               if (is_alu_op(bus.CMD_OPCODE)) begin
                  alu_op1_d    = rs1_data_s;
                  alu_op2_d    = rs2_data_s;
                  alu_opcode_d = bus.CMD_OPCODE;
               end else begin
                  alu_op1_d    = alu_op1_q;
                  alu_op2_d    = alu_op2_q;
                  alu_opcode_d = alu_opcode_q;
               end
               state_d = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            if (is_alu_op(op_q)) begin
               rsp_data_d = bus.ALU_RES;
               rsp_psr_d  = bus.ALU_PSR;
               rsp_err_d  = 1'b0;
               we_s       = 1'b1;
               wr_data_s  = bus.ALU_RES;
            end else if (op_q == LDI) begin
               rsp_data_d = imm_q;
               rsp_psr_d  = ldi_psr_s;
               rsp_err_d  = 1'b0;
               we_s       = 1'b1;
               wr_data_s  = imm_q;
            end else begin
               rsp_data_d = {WIDTH{1'b0}};
               rsp_psr_d  = 2'b00;
               rsp_err_d  = 1'b1;
               we_s       = 1'b0;
               wr_data_s  = {WIDTH{1'b0}};
            end
            state_d = RESP;
         end
         RESP: begin
            if (bus.RSP_READY) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      cmd_ready_d = (state_d == IDLE) ? 1'b1 : 1'b0;
      rsp_valid_d = (state_d == RESP) ? 1'b1 : 1'b0;
   end

   // State and output registers; reset aborts any command in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         op_q         <= 4'b0000;
         rd_q         <= {AW{1'b0}};
         imm_q        <= {WIDTH{1'b0}};
         alu_op1_q    <= {WIDTH{1'b0}};
         alu_op2_q    <= {WIDTH{1'b0}};
         alu_opcode_q <= 4'b0000;
         rsp_data_q   <= {WIDTH{1'b0}};
         rsp_psr_q    <= 2'b00;
         rsp_err_q    <= 1'b0;
         rsp_valid_q  <= 1'b0;
         cmd_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         rd_q         <= rd_d;
         imm_q        <= imm_d;
         alu_op1_q    <= alu_op1_d;
         alu_op2_q    <= alu_op2_d;
         alu_opcode_q <= alu_opcode_d;
         rsp_data_q   <= rsp_data_d;
         rsp_psr_q    <= rsp_psr_d;
         rsp_err_q    <= rsp_err_d;
         rsp_valid_q  <= rsp_valid_d;
         cmd_ready_q  <= cmd_ready_d;
      end
   end

   assign bus.CMD_READY  = cmd_ready_q;
   assign bus.ALU_OP1    = alu_op1_q;
   assign bus.ALU_OP2    = alu_op2_q;
   assign bus.ALU_OPCODE = alu_opcode_q;
   assign bus.RSP_VALID  = rsp_valid_q;
   assign bus.RSP_DATA   = rsp_data_q;
   assign bus.RSP_PSR    = rsp_psr_q;
   assign bus.RSP_ERR    = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer driving the real ALU; expected responses
// are queued when a command is issued and compared when the response appears.
module tb_alu_sequencer;
   import alu_pkg::*;

   localparam int WIDTH = 32;
   localparam int REGS  = 8;
   localparam int AW    = 3;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [1:0]       psr;
      logic             err;
   } rsp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   rsp_t             sb[$];
   logic [WIDTH-1:0] model_rf [REGS];
   logic [WIDTH-1:0] exp_op1;
   logic [WIDTH-1:0] exp_op2;
   logic [3:0]       exp_opc;

   always #5 clk = ~clk;

   alu_sequencer_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   alu_sequencer #(.WIDTH(WIDTH), .REGS(REGS)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
   );

   alu #(.WIDTH(WIDTH)) u_alu (
      .op1    (bus.ALU_OP1),
      .op2    (bus.ALU_OP2),
      .opcode (bus.ALU_OPCODE),
      .res    (bus.ALU_RES),
      .psr    (bus.ALU_PSR)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 32'(bus.CMD_READY), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(bus.RSP_VALID), 32'd0);
      chk({tag, "_rsp_data"}, bus.RSP_DATA, 32'd0);
      chk({tag, "_rsp_psr"}, 32'(bus.RSP_PSR), 32'd0);
      chk({tag, "_rsp_err"}, 32'(bus.RSP_ERR), 32'd0);
      chk({tag, "_alu_op1"}, bus.ALU_OP1, 32'd0);
      chk({tag, "_alu_op2"}, bus.ALU_OP2, 32'd0);
      chk({tag, "_alu_opc"}, 32'(bus.ALU_OPCODE), 32'd0);
   endtask

   // Present a command and wait (bounded) for the cycle in which it is accepted.
   task automatic send(input string tag, input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [31:0] imm);
      bit ok;
      @(negedge clk);
      bus.CMD_VALID  = 1'b1;
      bus.CMD_OPCODE = op;
      bus.CMD_RD     = rd;
      bus.CMD_RS1    = rs1;
      bus.CMD_RS2    = rs2;
      bus.CMD_IMM    = imm;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.CMD_READY === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      #1 bus.CMD_VALID = 1'b0;
   endtask

   task automatic run_cmd(input string tag, input logic [3:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2, input logic [31:0] imm,
                          input logic [31:0] edata, input logic [1:0] epsr, input logic eerr,
                          input int hold);
      rsp_t e;
      int   cyc;
      e.data = edata;
      e.psr  = epsr;
      e.err  = eerr;
      sb.push_back(e);
      if (is_alu_op(op)) begin
         exp_op1 = model_rf[rs1];
         exp_op2 = model_rf[rs2];
         exp_opc = op;
      end
      if (!eerr) model_rf[rd] = edata;

      send(tag, op, rd, rs1, rs2, imm);
      @(negedge clk);
      cyc = 1;
      chk({tag, "_alu_op1"}, bus.ALU_OP1, exp_op1);
      chk({tag, "_alu_op2"}, bus.ALU_OP2, exp_op2);
      chk({tag, "_alu_opc"}, 32'(bus.ALU_OPCODE), 32'(exp_opc));
      while (bus.RSP_VALID !== 1'b1 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'd2);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_data"}, bus.RSP_DATA, e.data);
         chk({tag, "_psr"}, 32'(bus.RSP_PSR), 32'(e.psr));
         chk({tag, "_err"}, 32'(bus.RSP_ERR), 32'(e.err));
         if (hold > 0) begin
            bus.CMD_VALID  = 1'b1;
            bus.CMD_OPCODE = LDI;
            bus.CMD_RD     = rd;
            bus.CMD_IMM    = 32'hDEAD_BEEF;
            for (int i = 0; i < hold; i++) begin
               @(negedge clk);
               chk({tag, "_hold_valid"}, 32'(bus.RSP_VALID), 32'd1);
               chk({tag, "_hold_ready"}, 32'(bus.CMD_READY), 32'd0);
               chk({tag, "_hold_data"}, bus.RSP_DATA, e.data);
               chk({tag, "_hold_psr"}, 32'(bus.RSP_PSR), 32'(e.psr));
               chk({tag, "_hold_err"}, 32'(bus.RSP_ERR), 32'(e.err));
            end
            bus.CMD_VALID = 1'b0;
         end
      end
      bus.RSP_READY = 1'b1;
      @(posedge clk);
      #1 bus.RSP_READY = 1'b0;
      @(negedge clk);
      chk({tag, "_ready_after"}, 32'(bus.CMD_READY), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst            = 1'b1;
      bus.CMD_VALID  = 1'b0;
      bus.CMD_OPCODE = 4'd0;
      bus.CMD_RD     = 3'd0;
      bus.CMD_RS1    = 3'd0;
      bus.CMD_RS2    = 3'd0;
      bus.CMD_IMM    = 32'd0;
      bus.RSP_READY  = 1'b0;
      for (int i = 0; i < REGS; i++) model_rf[i] = 32'd0;
      exp_op1 = 32'd0;
      exp_op2 = 32'd0;
      exp_opc = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("por");
      rst = 1'b0;

      run_cmd("ldi_r1",  LDI,     3'd1, 3'd0, 3'd0, 32'd5, 32'd5,         2'b00, 1'b0, 0);
      run_cmd("ldi_r2",  LDI,     3'd2, 3'd0, 3'd0, 32'd7, 32'd7,         2'b00, 1'b0, 0);
      run_cmd("add_r3",  ADD,     3'd3, 3'd1, 3'd2, 32'd0, 32'd12,        2'b00, 1'b0, 0);
      run_cmd("sub_r4",  SUB,     3'd4, 3'd1, 3'd2, 32'd0, 32'hFFFF_FFFE, 2'b10, 1'b0, 0);
      run_cmd("sub_r5",  SUB,     3'd5, 3'd1, 3'd1, 32'd0, 32'd0,         2'b01, 1'b0, 0);
      run_cmd("slt_r6",  SLT,     3'd6, 3'd1, 3'd2, 32'd0, 32'd1,         2'b00, 1'b0, 0);
      run_cmd("ill_r3",  4'b0110, 3'd3, 3'd1, 3'd2, 32'd9, 32'd0,         2'b00, 1'b1, 0);
      run_cmd("add_r7",  ADD,     3'd7, 3'd3, 3'd0, 32'd0, 32'd12,        2'b00, 1'b0, 0);
      run_cmd("ldi_r1b", LDI,     3'd1, 3'd0, 3'd0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 2'b10, 1'b0, 0);
      run_cmd("ldi_r2b", LDI,     3'd2, 3'd0, 3'd0, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 2'b00, 1'b0, 0);
      run_cmd("or_r4",   OR,      3'd4, 3'd1, 3'd2, 32'd0, 32'hFFF0_FFF0, 2'b10, 1'b0, 0);
      run_cmd("and_r5",  AND,     3'd5, 3'd1, 3'd2, 32'd0, 32'h00F0_00F0, 2'b00, 1'b0, 0);
      run_cmd("nor_r6",  NOR,     3'd6, 3'd1, 3'd2, 32'd0, 32'h000F_000F, 2'b00, 1'b0, 0);
      run_cmd("ldi_zero", LDI,    3'd0, 3'd0, 3'd0, 32'd0, 32'd0,         2'b01, 1'b0, 0);
      run_cmd("ill_f",   4'b1111, 3'd0, 3'd1, 3'd2, 32'd3, 32'd0,         2'b00, 1'b1, 0);
      run_cmd("hold_r7", LDI,     3'd7, 3'd0, 3'd0, 32'h0000_1234, 32'h0000_1234, 2'b00, 1'b0, 5);
      run_cmd("chk_r7",  ADD,     3'd7, 3'd7, 3'd0, 32'd0, 32'h0000_1234, 2'b00, 1'b0, 0);

      // Reset while ADD R3 is executing: the command must vanish without trace.
      send("abort", ADD, 3'd3, 3'd1, 3'd2, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("abort");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_rsp", 32'(bus.RSP_VALID), 32'd0);
      end
      for (int i = 0; i < REGS; i++) model_rf[i] = 32'd0;
      exp_op1 = 32'd0;
      exp_op2 = 32'd0;
      exp_opc = 4'd0;
      run_cmd("post_r3", ADD,     3'd7, 3'd3, 3'd0, 32'd0, 32'd0,         2'b01, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
